generador_cubos: RTL



---
 rtl/cubos_pkg.sv | 22 ++
 rtl/lfsr_cubos.sv | 36 +++
 rtl/generador_cubos.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cubos_pkg.sv
// Shared definitions for the cube-pattern generator.
//   estado_t        game-state enumeration (ESPERA, CORRIENDO, PAUSADO)
//   ANCHO_CARRILES  number of lanes in the cube pattern
//   LFSR_TAPS       Galois tap mask for the 16-bit right-shift LFSR
//   FILTRO_LLENO    replacement for an all-lanes-blocked pattern
//   FILTRO_VACIO    replacement for an empty pattern
package cubos_pkg;

  typedef enum logic [1:0] {
    ESPERA,
    CORRIENDO,
    PAUSADO
  } estado_t;

  localparam int unsigned ANCHO_CARRILES = 5;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [ANCHO_CARRILES-1:0] FILTRO_LLENO = 5'b11011;
  localparam logic [ANCHO_CARRILES-1:0] FILTRO_VACIO = 5'b00100;

endpackage

// File: rtl/lfsr_cubos.sv
// 16-bit Galois LFSR (right shift) used as the cube-pattern source.
//   clk      system clock
//   reset    synchronous active-high reset, loads SEMILLA
//   avanzar  advance one step on this edge
//   lfsr     current state
//   lfsr_n   state after one step (combinational look-ahead)
module lfsr_cubos
  import cubos_pkg::*;
#(
  parameter logic [15:0] SEMILLA = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avanzar,
  output logic [15:0] lfsr,
  output logic [15:0] lfsr_n
);

  if (SEMILLA == 16'h0000) begin : g_semilla_invalida
    $error("lfsr_cubos: SEMILLA must be nonzero");
  end

  logic [15:0] lfsr_q;

  assign lfsr_n = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  assign lfsr   = lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEMILLA;
    end else if (avanzar) begin
      lfsr_q <= lfsr_n;
    end
  end

endmodule

// File: rtl/generador_cubos.sv
// Cube-pattern generator: game-state FSM, spawn period counter, lane filter
// and difficulty level tracking.
//   clk                      system clock
//   reset                    synchronous active-high reset
//   iniciar                  start game (only honoured in ESPERA)
//   pausa                    level-sensitive pause
//   fin_juego                game over, back to ESPERA
//   cubos_entrada            current 5-lane pattern, bit 0 = leftmost lane
//   pulso_habilitador        one-cycle spawn strobe
//   bandera_habilitar_cubos  high while CORRIENDO
//   nivel                    current difficulty level
module generador_cubos
  import cubos_pkg::*;
#(
  parameter int unsigned PERIODO_BASE    = 25_000_000,
  parameter int unsigned PASO_NIVEL      = 2_500_000,
  parameter int unsigned NIVEL_MAX       = 7,
  parameter int unsigned CUBOS_POR_NIVEL = 16,
  parameter logic [15:0] SEMILLA         = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic                      pausa,
  input  logic                      fin_juego,
  output logic [ANCHO_CARRILES-1:0] cubos_entrada,
  output logic                      pulso_habilitador,
  output logic                      bandera_habilitar_cubos,
  output logic [2:0]                nivel
);

  localparam int unsigned AnchoCnt   = $clog2(PERIODO_BASE);
  localparam int unsigned AnchoSpawn = $clog2(CUBOS_POR_NIVEL + 1);

  // The shortest period occurs at NIVEL_MAX; it must still leave room to count.
  if (PERIODO_BASE < NIVEL_MAX * PASO_NIVEL + 2) begin : g_periodo_invalido
    $error("generador_cubos: period at NIVEL_MAX is below 2 cycles");
  end
  if (NIVEL_MAX > 7) begin : g_nivel_invalido
    $error("generador_cubos: NIVEL_MAX must fit in 3 bits");
  end
  if (CUBOS_POR_NIVEL == 0) begin : g_cubos_invalido
    $error("generador_cubos: CUBOS_POR_NIVEL must be nonzero");
  end

  function automatic logic [AnchoCnt-1:0] recarga(input logic [2:0] n);
    return AnchoCnt'(PERIODO_BASE - 32'(n) * PASO_NIVEL - 1);
  endfunction

  // Never emit a fully blocked or fully empty row.
  function automatic logic [ANCHO_CARRILES-1:0] filtrar(input logic [ANCHO_CARRILES-1:0] p);
    if (p == '1) return FILTRO_LLENO;
    if (p == '0) return FILTRO_VACIO;
    return p;
  endfunction

  estado_t                   estado_q;
  logic [AnchoCnt-1:0]       cuenta_q;
  logic [ANCHO_CARRILES-1:0] cubos_q;
  logic                      pulso_q;
  logic [2:0]                nivel_q, nivel_d;
  logic [AnchoSpawn-1:0]     n_spawn_q, n_spawn_d;

  logic        spawn;
  logic [15:0] lfsr_actual, lfsr_n;
  logic        unused_lfsr;

  // Spawn fires only when the counter expires with no higher-priority event.
  assign spawn = (estado_q != ESPERA) && !fin_juego && !pausa && (cuenta_q == '0);

  lfsr_cubos #(
    .SEMILLA(SEMILLA)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .avanzar(spawn),
    .lfsr   (lfsr_actual),
    .lfsr_n (lfsr_n)
  );

  assign unused_lfsr = ^{lfsr_actual, lfsr_n[15:ANCHO_CARRILES]};

  always_comb begin
    n_spawn_d = n_spawn_q + AnchoSpawn'(1);
    nivel_d   = nivel_q;
    if (n_spawn_d == AnchoSpawn'(CUBOS_POR_NIVEL)) begin
      n_spawn_d = '0;
      if (nivel_q < 3'(NIVEL_MAX)) nivel_d = nivel_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= ESPERA;
      cuenta_q  <= '0;
      cubos_q   <= '0;
      pulso_q   <= 1'b0;
      nivel_q   <= '0;
      n_spawn_q <= '0;
    end else begin
      pulso_q <= 1'b0;
      case (estado_q)
        ESPERA: begin
          if (iniciar && !fin_juego) begin
            estado_q  <= CORRIENDO;
            cuenta_q  <= recarga(3'd0);
            nivel_q   <= '0;
            n_spawn_q <= '0;
          end
        end
        default: begin
          if (fin_juego) begin
            estado_q  <= ESPERA;
            cuenta_q  <= '0;
            cubos_q   <= '0;
            nivel_q   <= '0;
            n_spawn_q <= '0;
          end else if (pausa) begin
            estado_q <= PAUSADO;
          end else begin
            // Resuming from PAUSADO counts on the same edge, so a pause of
            // N cycles costs exactly N cycles.
            estado_q <= CORRIENDO;
            if (cuenta_q != '0) begin
              cuenta_q <= cuenta_q - AnchoCnt'(1);
            end else begin
              pulso_q   <= 1'b1;
              cubos_q   <= filtrar(lfsr_n[ANCHO_CARRILES-1:0]);
              n_spawn_q <= n_spawn_d;
              nivel_q   <= nivel_d;
              cuenta_q  <= recarga(nivel_d);
            end
          end
        end
      endcase
    end
  end

  assign cubos_entrada           = cubos_q;
  assign pulso_habilitador       = pulso_q;
  assign bandera_habilitar_cubos = (estado_q == CORRIENDO);
  assign nivel                   = nivel_q;

endmodule
